// File: rtl/spw_tx_pkg.sv
// Shared character-type codes, FSM encoding and credit constants for the
// SpaceWire transmit scheduler.
package spw_tx_pkg;

  localparam logic [2:0] TX_DATA = 3'd0;
  localparam logic [2:0] TX_EOP  = 3'd1;
  localparam logic [2:0] TX_EEP  = 3'd2;
  localparam logic [2:0] TX_FCT  = 3'd3;
  localparam logic [2:0] TX_TIME = 3'd4;

  localparam int unsigned CREDIT_STEP = 8;
  localparam int unsigned CREDIT_MAX  = 56;
  localparam int unsigned CREDIT_W    = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StWait  = 2'd2,
    StSend  = 2'd3
  } sched_state_e;

  // Bit 8 marks a control word: 0x00 is end-of-packet, any other value error-end.
  function automatic logic [2:0] nchar_type(input logic is_ctrl, input logic [7:0] data);
    if (!is_ctrl) begin
      return TX_DATA;
    end
    return (data == 8'h00) ? TX_EOP : TX_EEP;
  endfunction

  function automatic logic is_nchar(input logic [2:0] tx_type);
    return (tx_type == TX_DATA) || (tx_type == TX_EOP) || (tx_type == TX_EEP);
  endfunction

endpackage

// File: rtl/spw_tx_scheduler_if.sv
// Character handshake between the transmit scheduler (master) and the
// TX encoder (slave).
interface spw_tx_scheduler_if;
  import spw_tx_pkg::*;

  logic       tx_valid;
  logic [2:0] tx_type;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_type,
    output tx_data,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_type,
    input  tx_data,
    output tx_ready
  );

endinterface

// File: rtl/spw_tx_credit.sv
// Transmit credit counter: +CreditStep per received FCT, -1 per N-char sent,
// refuses an FCT that would push the credit past CreditMax.
module spw_tx_credit
  import spw_tx_pkg::*;
#(
  parameter int unsigned CreditMax  = CREDIT_MAX,
  parameter int unsigned CreditStep = CREDIT_STEP
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                got_fct_i,
  input  logic                nchar_sent_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                credit_error_o
);

  localparam int unsigned SumW = CREDIT_W + 1;

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                error_q, error_d;
  logic [SumW-1:0]     sum;

  always_comb begin
    sum = {1'b0, credit_q}
        + (got_fct_i ? SumW'(CreditStep) : '0)
        - {{CREDIT_W{1'b0}}, nchar_sent_i};
    credit_d = sum[CREDIT_W-1:0];
    error_d  = 1'b0;
    if (clear_i) begin
      credit_d = '0;
    end else if (got_fct_i && (sum > SumW'(CreditMax))) begin
      // Refuse the FCT but still account for an N-char leaving this cycle.
      credit_d = credit_q - {{(CREDIT_W - 1){1'b0}}, nchar_sent_i};
      error_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= '0;
      error_q  <= 1'b0;
    end else begin
      credit_q <= credit_d;
      error_q  <= error_d;
    end
  end

  assign credit_o       = credit_q;
  assign credit_error_o = error_q;

endmodule

// File: rtl/spw_tx_scheduler.sv
// SpaceWire transmit scheduler: arbitrates time-codes, FCTs and FIFO N-chars
// onto the encoder handshake. Define SPW_TX_SCHED_STATS_EN for nchar_count_o.
module spw_tx_scheduler #(
  parameter int unsigned DWIDTH     = 9,
  parameter int unsigned RD_LATENCY = 2,
  parameter int unsigned CREDIT_MAX = spw_tx_pkg::CREDIT_MAX
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      link_run_i,
  input  logic                      fifo_empty_i,
  input  logic [DWIDTH-1:0]         fifo_data_i,
  output logic                      fifo_rd_en_o,
  input  logic                      got_fct_i,
  input  logic                      fct_req_i,
  input  logic                      tick_in_i,
  input  logic [7:0]                time_in_i,
  spw_tx_scheduler_if.master        tx,
  output logic [5:0]                credit_o,
  output logic                      credit_error_o
`ifdef SPW_TX_SCHED_STATS_EN
  ,
  output logic [15:0]               nchar_count_o
`endif
);

  import spw_tx_pkg::*;

  localparam int unsigned CntW = 2;

  sched_state_e    state_q, state_d;
  logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
  logic [2:0]      type_q, type_d;
  logic [7:0]      data_q, data_d;
  logic            time_pend_q, time_pend_d;
  logic [7:0]      time_val_q, time_val_d;
  logic            fct_pend_q, fct_pend_d;
  logic            xfer;
  logic            nchar_sent;
  logic [5:0]      credit;

  assign xfer       = (state_q == StSend) && tx.tx_ready;
  assign nchar_sent = xfer && is_nchar(type_q);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    type_d       = type_q;
    data_d       = data_q;
    time_pend_d  = time_pend_q;
    time_val_d   = time_val_q;
    fct_pend_d   = fct_pend_q;
    fifo_rd_en_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (time_pend_q) begin
          type_d  = TX_TIME;
          data_d  = time_val_q;
          state_d = StSend;
        end else if (fct_pend_q) begin
          type_d  = TX_FCT;
          data_d  = 8'h00;
          state_d = StSend;
        end else if (!fifo_empty_i && (credit != '0)) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        fifo_rd_en_o = link_run_i;
        wait_cnt_d   = '0;
        state_d      = StWait;
      end
      StWait: begin
        if (wait_cnt_q == CntW'(RD_LATENCY - 1)) begin
          type_d  = nchar_type(fifo_data_i[DWIDTH-1], fifo_data_i[7:0]);
          data_d  = fifo_data_i[7:0];
          state_d = StSend;
        end else begin
          wait_cnt_d = wait_cnt_q + CntW'(1);
        end
      end
      StSend: begin
        if (tx.tx_ready) begin
          state_d = StIdle;
          if (type_q == TX_TIME) time_pend_d = 1'b0;
          if (type_q == TX_FCT)  fct_pend_d  = 1'b0;
        end
      end
    endcase

    // A new request in the same cycle as the matching transfer survives it.
    if (tick_in_i) begin
      time_pend_d = 1'b1;
      time_val_d  = time_in_i;
    end
    if (fct_req_i) begin
      fct_pend_d = 1'b1;
    end

    if (!link_run_i) begin
      state_d     = StIdle;
      time_pend_d = 1'b0;
      fct_pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      type_q      <= TX_DATA;
      data_q      <= 8'h00;
      time_pend_q <= 1'b0;
      time_val_q  <= 8'h00;
      fct_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      type_q      <= type_d;
      data_q      <= data_d;
      time_pend_q <= time_pend_d;
      time_val_q  <= time_val_d;
      fct_pend_q  <= fct_pend_d;
    end
  end

  assign tx.tx_valid = (state_q == StSend);
  assign tx.tx_type  = type_q;
  assign tx.tx_data  = data_q;

  spw_tx_credit #(
    .CreditMax  (CREDIT_MAX),
    .CreditStep (CREDIT_STEP)
  ) u_credit (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .clear_i        (!link_run_i),
    .got_fct_i      (got_fct_i),
    .nchar_sent_i   (nchar_sent),
    .credit_o       (credit),
    .credit_error_o (credit_error_o)
  );

  assign credit_o = credit;

`ifdef SPW_TX_SCHED_STATS_EN
  // Survives link drops; only the system reset clears it.
  logic [15:0] nchar_count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      nchar_count_q <= 16'h0000;
    end else if (nchar_sent) begin
      nchar_count_q <= nchar_count_q + 16'd1;
    end
  end

  assign nchar_count_o = nchar_count_q;
`endif

endmodule

// File: tb/tb_spw_tx_scheduler.sv
// Directed and randomized bench for spw_tx_scheduler; the random phase checks
// the DUT against a credit/pending-request/FIFO-order reference model.
module tb_spw_tx_scheduler;

  localparam int unsigned RDL = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       link_run = 1'b0;
  logic       fifo_empty;
  logic [8:0] fifo_data;
  logic       fifo_rd_en;
  logic       got_fct = 1'b0;
  logic       fct_req = 1'b0;
  logic       tick_in = 1'b0;
  logic [7:0] time_in = 8'h00;
  logic [5:0] credit;
  logic       credit_error;

  spw_tx_scheduler_if tx_if ();

`ifdef SPW_TX_SCHED_STATS_EN
  logic [15:0] nchar_count;
  int unsigned ncount_ref = 0;
`endif

  spw_tx_scheduler #(
    .DWIDTH     (9),
    .RD_LATENCY (RDL),
    .CREDIT_MAX (56)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .link_run_i     (link_run),
    .fifo_empty_i   (fifo_empty),
    .fifo_data_i    (fifo_data),
    .fifo_rd_en_o   (fifo_rd_en),
    .got_fct_i      (got_fct),
    .fct_req_i      (fct_req),
    .tick_in_i      (tick_in),
    .time_in_i      (time_in),
    .tx             (tx_if),
    .credit_o       (credit),
    .credit_error_o (credit_error)
`ifdef SPW_TX_SCHED_STATS_EN
    ,
    .nchar_count_o  (nchar_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: word appears on fifo_data RDL cycles after the rd_en cycle.
  logic [8:0]  fifo_mem [0:1023];
  int unsigned wr_ptr = 0;
  int unsigned rd_ptr = 0;
  logic [8:0]  pipe [RDL];

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = pipe[RDL-1];

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      pipe[0] <= fifo_mem[rd_ptr[9:0]];
      rd_ptr  <= rd_ptr + 1;
    end else begin
      pipe[0] <= 9'h0DE;
    end
    for (int i = 1; i < RDL; i++) pipe[i] <= pipe[i-1];
  end

`ifdef SPW_TX_SCHED_STATS_EN
  always @(posedge clk) begin
    if (rst_n && tx_if.tx_valid && tx_if.tx_ready && (tx_if.tx_type <= 3'd2))
      ncount_ref <= ncount_ref + 1;
  end
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input logic [8:0] w);
    fifo_mem[wr_ptr[9:0]] = w;
    wr_ptr++;
  endtask

  task automatic link_clear();
    link_run = 1'b0;
    tick();
    link_run = 1'b1;
  endtask

  logic [2:0] got_type [8];
  logic [7:0] got_data [8];
  int         n_got;

  task automatic collect(input int want);
    int n;
    n_got = 0;
    n = 0;
    while (n_got < want && n < 60) begin
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        got_type[n_got] = tx_if.tx_type;
        got_data[n_got] = tx_if.tx_data;
        n_got++;
      end
      tick();
      n++;
    end
    chk("collect_count", n_got, want);
  endtask

  function automatic logic [2:0] exp_type(input logic [8:0] w);
    if (!w[8]) return 3'd0;
    if (w[7:0] == 8'h00) return 3'd1;
    return 3'd2;
  endfunction

  // Reference model state for the random phase.
  int          exp_credit;
  bit          tpend_m, fpend_m;
  logic [7:0]  tval_m;
  int unsigned sb_idx;
  logic        prev_valid, prev_ready;
  logic [2:0]  prev_type;
  logic [7:0]  prev_data;

  task automatic rand_cycle(input bit drain);
    logic [8:0] w;
    chk("credit", credit, exp_credit);
    chk("credit_error_idle", credit_error, 0);
    if (prev_valid && !prev_ready) begin
      chk("hold_valid", tx_if.tx_valid, 1);
      chk("hold_type", tx_if.tx_type, prev_type);
      chk("hold_data", tx_if.tx_data, prev_data);
    end
    if (drain) begin
      got_fct        = (exp_credit < 2);
      tick_in        = 1'b0;
      fct_req        = 1'b0;
      tx_if.tx_ready = 1'b1;
    end else begin
      got_fct        = (exp_credit <= 48) && ($urandom_range(0, 9) == 0);
      tick_in        = !tpend_m && ($urandom_range(0, 29) == 0);
      time_in        = 8'($urandom);
      fct_req        = !fpend_m && ($urandom_range(0, 19) == 0);
      tx_if.tx_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0 && wr_ptr < 1000)
        push({($urandom_range(0, 7) == 0), 8'($urandom)});
    end
    if (tx_if.tx_valid && tx_if.tx_ready) begin
      case (tx_if.tx_type)
        3'd4: begin
          chk("time_was_pending", tpend_m, 1);
          chk("time_value", tx_if.tx_data, tval_m);
          tpend_m = 1'b0;
        end
        3'd3: begin
          chk("fct_was_pending", fpend_m, 1);
          fpend_m = 1'b0;
        end
        3'd0, 3'd1, 3'd2: begin
          chk("nchar_available", sb_idx < wr_ptr, 1);
          chk("nchar_credit_positive", exp_credit > 0, 1);
          w = fifo_mem[sb_idx[9:0]];
          chk("nchar_type", tx_if.tx_type, exp_type(w));
          chk("nchar_data", tx_if.tx_data, w[7:0]);
          sb_idx++;
          exp_credit--;
        end
        default: chk("tx_type_legal", tx_if.tx_type, 0);
      endcase
    end
    if (tick_in) begin
      tpend_m = 1'b1;
      tval_m  = time_in;
    end
    if (fct_req) fpend_m = 1'b1;
    if (got_fct) exp_credit += 8;
    prev_valid = tx_if.tx_valid;
    prev_ready = tx_if.tx_ready;
    prev_type  = tx_if.tx_type;
    prev_data  = tx_if.tx_data;
    tick();
  endtask

  initial begin
    int n;
    int pulses;
    tx_if.tx_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_tx_valid", tx_if.tx_valid, 0);
    chk("rst_tx_type", tx_if.tx_type, 0);
    chk("rst_tx_data", tx_if.tx_data, 0);
    chk("rst_credit", credit, 0);
    chk("rst_credit_error", credit_error, 0);
    chk("rst_fifo_rd_en", fifo_rd_en, 0);
    rst_n    = 1'b1;
    link_run = 1'b1;
    tick();

    // 1: single DATA char, latency and credit
    push(9'h041);
    got_fct = 1'b1;
    tick();
    got_fct = 1'b0;
    chk("t1_credit_after_fct", credit, 8);
    n = 0;
    pulses = 0;
    while (!tx_if.tx_valid && n < 20) begin
      pulses += int'(fifo_rd_en);
      tick();
      n++;
    end
    chk("t1_latency", n, 4);
    chk("t1_rd_pulses", pulses, 1);
    chk("t1_type", tx_if.tx_type, 0);
    chk("t1_data", tx_if.tx_data, 8'h41);
    tx_if.tx_ready = 1'b1;
    tick();
    tx_if.tx_ready = 1'b0;
    chk("t1_valid_drop", tx_if.tx_valid, 0);
    chk("t1_credit_after", credit, 7);

    // 2: TIME beats FCT beats DATA
    link_clear();
    push(9'h033);
    got_fct        = 1'b1;
    tick_in        = 1'b1;
    time_in        = 8'h2A;
    fct_req        = 1'b1;
    tx_if.tx_ready = 1'b1;
    tick();
    got_fct = 1'b0;
    tick_in = 1'b0;
    fct_req = 1'b0;
    collect(3);
    chk("t2_first_type", got_type[0], 4);
    chk("t2_first_data", got_data[0], 8'h2A);
    chk("t2_second_type", got_type[1], 3);
    chk("t2_third_type", got_type[2], 0);
    chk("t2_third_data", got_data[2], 8'h33);
    chk("t2_credit", credit, 7);
    tx_if.tx_ready = 1'b0;

    // 3: fill to 56, then overflow
    link_clear();
    for (int i = 0; i < 7; i++) begin
      got_fct = 1'b1;
      tick();
      chk("t3_no_error", credit_error, 0);
    end
    got_fct = 1'b0;
    chk("t3_credit_full", credit, 56);
    got_fct = 1'b1;
    tick();
    got_fct = 1'b0;
    chk("t3_credit_held", credit, 56);
    chk("t3_error_pulse", credit_error, 1);
    tick();
    chk("t3_error_cleared", credit_error, 0);

    // 4: EOP then EEP
    push(9'h100);
    push(9'h101);
    tx_if.tx_ready = 1'b1;
    collect(2);
    tx_if.tx_ready = 1'b0;
    chk("t4_eop", got_type[0], 1);
    chk("t4_eep", got_type[1], 2);
    chk("t4_credit", credit, 54);

    // 5: backpressure holds the character
    push(9'h0A5);
    n = 0;
    while (!tx_if.tx_valid && n < 20) begin
      tick();
      n++;
    end
    chk("t5_valid_seen", tx_if.tx_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", tx_if.tx_valid, 1);
      chk("t5_hold_type", tx_if.tx_type, 0);
      chk("t5_hold_data", tx_if.tx_data, 8'hA5);
      chk("t5_hold_credit", credit, 54);
    end
    tx_if.tx_ready = 1'b1;
    tick();
    tx_if.tx_ready = 1'b0;
    chk("t5_valid_drop", tx_if.tx_valid, 0);
    chk("t5_credit_dec", credit, 53);
    tick();
    chk("t5_credit_single_dec", credit, 53);

    // 6: link drop during WAIT
    link_clear();
    got_fct = 1'b1;
    repeat (3) tick();
    got_fct = 1'b0;
    for (int i = 0; i < 4; i++) push(9'(8'h11 + i));
    tx_if.tx_ready = 1'b1;
    collect(4);
    tx_if.tx_ready = 1'b0;
    chk("t6_credit_20", credit, 20);
    push(9'h0EE);
    n = 0;
    while (!fifo_rd_en && n < 20) begin
      tick();
      n++;
    end
    chk("t6_fetch_seen", fifo_rd_en, 1);
    tick();
    link_run = 1'b0;
    tick();
    chk("t6_valid_abort", tx_if.tx_valid, 0);
    chk("t6_credit_clear", credit, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_stay_idle", tx_if.tx_valid, 0);
    end
    link_run       = 1'b1;
    got_fct        = 1'b1;
    tx_if.tx_ready = 1'b1;
    push(9'h077);
    tick();
    got_fct = 1'b0;
    collect(1);
    tx_if.tx_ready = 1'b0;
    chk("t6_resume_type", got_type[0], 0);
    chk("t6_resume_data", got_data[0], 8'h77);
    chk("t6_resume_credit", credit, 7);

    // Randomized run against the reference model
    link_clear();
    exp_credit = 0;
    tpend_m    = 1'b0;
    fpend_m    = 1'b0;
    tval_m     = 8'h00;
    sb_idx     = wr_ptr;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_type  = 3'd0;
    prev_data  = 8'h00;
    for (int i = 0; i < 3000; i++) rand_cycle(1'b0);
    n = 0;
    while (!(sb_idx == wr_ptr && !tpend_m && !fpend_m) && n < 3000) begin
      rand_cycle(1'b1);
      n++;
    end
    chk("drain_complete", (sb_idx == wr_ptr) && !tpend_m && !fpend_m, 1);
    got_fct        = 1'b0;
    tx_if.tx_ready = 1'b0;
    tick();

`ifdef SPW_TX_SCHED_STATS_EN
    chk("nchar_count", nchar_count, ncount_ref[15:0]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spw_tx_scheduler.md
Name: spw_tx_scheduler

Overview:
Sequences the SpaceWire transmit path. Arbitrates between time-codes, flow-control tokens (FCT) and N-chars popped from the 9-bit TX FIFO, and presents one character at a time to the TX encoder over a valid/ready handshake. Owns the link's transmit credit, which grows by 8 per received FCT and shrinks by 1 per N-char sent. Sits between the TX FIFO and the TX encoder, and is gated by the link FSM's Run state.

Parameters:
DWIDTH, 9, FIFO word width; bit 8 is the control flag.
RD_LATENCY, 2, cycles from the fifo_rd_en pulse until fifo_data is valid (1..3).
CREDIT_MAX, 56, maximum credit in N-chars.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
link_run  in  1  link FSM is in Run; low aborts all activity.
fifo_empty  in  1  TX FIFO empty flag.
fifo_data  in  DWIDTH  FIFO read data.
fifo_rd_en  out  1  one-cycle pop request.
got_fct  in  1  one-cycle pulse: FCT received from the far end.
fct_req  in  1  one-cycle pulse: receiver asks for one FCT to be sent.
tick_in  in  1  one-cycle pulse: time-code request.
time_in  in  8  time-code value, sampled with tick_in.
tx_valid  out  1  character offered to the encoder.
tx_type  out  3  0 DATA, 1 EOP, 2 EEP, 3 FCT, 4 TIME.
tx_data  out  8  data byte or time-code value.
tx_ready  in  1  encoder accepts; transfer occurs when tx_valid && tx_ready.
credit  out  6  current credit.
credit_error  out  1  one-cycle pulse on credit overflow.

Behaviour:
- Reset values: fifo_rd_en=0, tx_valid=0, tx_type=0, tx_data=0, credit=0, credit_error=0. FSM enters IDLE. time_pend and fct_pend are cleared.
- Pending requests:
  - tick_in sets time_pend and latches time_in. A second tick while pending overwrites the value.
  - fct_req sets fct_pend. Requests do not accumulate beyond one.
- FSM states: IDLE, FETCH, WAIT, SEND.
- IDLE (only when link_run=1). Priority, evaluated each cycle:
  1. time_pend: load TIME, go to SEND.
  2. else fct_pend: load FCT, go to SEND.
  3. else !fifo_empty && credit>0: go to FETCH.
  4. else stay in IDLE.
- FETCH: drive fifo_rd_en=1 for exactly one cycle, then go to WAIT.
- WAIT: count RD_LATENCY-1 cycles, then capture fifo_data. Decode it and go to SEND:
  - bit8=0: DATA, tx_data=fifo_data[7:0].
  - bit8=1 and [7:0]==0: EOP.
  - bit8=1 and [7:0]!=0: EEP.
- SEND: tx_valid=1 with type and data held stable until tx_ready. On transfer:
  - tx_valid drops the next cycle and the FSM returns to IDLE.
  - The pending flag for that type clears.
  - DATA/EOP/EEP decrement credit.
- An N-char already fetched is never preempted; time-codes wait until it is transferred.
- Latency: a pending time-code in IDLE gives tx_valid=1 on the next cycle. A FIFO char reaches tx_valid at 2+RD_LATENCY cycles after the IDLE decision.
- Credit arithmetic (6-bit):
  - got_fct adds 8.
  - If credit+8 would exceed CREDIT_MAX: credit is unchanged and credit_error pulses.
  - got_fct together with an N-char transfer in the same cycle: net +7, overflow checked against the +7 result.
  - Credit never wraps below 0, because fetching requires credit>0.
- link_run low, at any time: next cycle FSM=IDLE, tx_valid=0, credit=0, both pending flags cleared, and any captured N-char is discarded. Stays idle until link_run=1.

Optional Feature:
SPW_TX_SCHED_STATS_EN
- Defined: adds output nchar_count[15:0]. It increments on every DATA/EOP/EEP transfer, wraps 0xFFFF→0, and clears on reset only (not on link_run low).
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Package spw_tx_pkg: tx_type codes (TX_DATA, TX_EOP, TX_EEP, TX_FCT, TX_TIME), FSM state encodings, CREDIT_STEP=8, CREDIT_MAX=56.
- One sub-module, spw_tx_credit: credit register, add/sub and overflow detect, with inputs got_fct, nchar_sent and clear.

Test Plan:
- Reset, link_run=1, got_fct once, FIFO holds 0x041 -> credit=8; one rd_en pulse; tx_valid with DATA/0x41 at cycle IDLE+4; credit=7 after transfer.
- tick_in(time=0x2A) and fct_req in the same cycle while FIFO is non-empty and credit=8 -> order of transfers TIME 0x2A, FCT, then DATA.
- 7 got_fct pulses -> credit=56; 8th pulse -> credit stays 56, credit_error one cycle high.
- FIFO words 0x100 and 0x101 -> EOP, then EEP; each decrements credit.
- tx_ready held low 5 cycles in SEND -> tx_valid, tx_type and tx_data stable; exactly one credit decrement on release.
- link_run dropped during WAIT, credit=20 -> next cycle tx_valid=0, credit=0, no transfer; resumes from IDLE when link_run rises.
